// File: rtl/my_pc_pkg.sv
// ---------------------------------------------------------------------------
// my_pc_pkg
// Shared definitions for the my_pc_n counter family.
//   pc_op_e   : the single operation chosen each cycle by the command decoder
//   decode_op : collapses the raw clr/load/inc/dec strobes into one operation
//               using the fixed priority clr > load > (inc&dec hold) > inc > dec
// ---------------------------------------------------------------------------
package my_pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } pc_op_e;

    // Simultaneous inc and dec cancel out, so they resolve to a hold rather
    // than letting inc win by position.
    function automatic pc_op_e decode_op(input logic clr,
                                         input logic load,
                                         input logic inc,
                                         input logic dec);
        pc_op_e op;
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (inc && dec) begin
            op = OP_HOLD;
        end else if (inc) begin
            op = OP_INC;
        end else if (dec) begin
            op = OP_DEC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/my_step_adder_n.sv
// ---------------------------------------------------------------------------
// my_step_adder_n
// Purely combinational a +/- STEP, evaluated one bit wider than the operand
// so the extra bit reports the out-of-range condition.
//   a     : WIDTH-bit operand
//   sub   : 1 = subtract STEP, 0 = add STEP
//   sum   : WIDTH-bit wrapped result
//   carry : 1 when the ideal result is above 2^WIDTH-1 (add) or below 0 (sub)
// ---------------------------------------------------------------------------
module my_step_adder_n #(
    parameter int     WIDTH = 16,
    parameter longint STEP  = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam logic [WIDTH:0] STEP_EXT = STEP[WIDTH:0];

    logic [WIDTH:0] result;

    // Both operands are below 2^WIDTH, so the top bit of the WIDTH+1 result
    // is set exactly on overflow for add and exactly on borrow for subtract.
    always_comb begin
        if (sub) begin
            result = {1'b0, a} - STEP_EXT;
        end else begin
            result = {1'b0, a} + STEP_EXT;
        end
    end

    assign sum   = result[WIDTH-1:0];
    assign carry = result[WIDTH];

endmodule

// File: rtl/my_pc_n.sv
// ---------------------------------------------------------------------------
// my_pc_n
// Parameterised up/down counter with clear, load, optional saturation and a
// one-cycle out-of-range flag.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (out = 0, ovf = 0)
//   clr    : synchronous clear to zero (highest priority)
//   load   : synchronous load of d
//   d      : load value
//   inc    : add STEP
//   dec    : subtract STEP (inc and dec together hold)
//   out    : registered counter value
//   ovf    : registered pulse, high for the cycle after an out-of-range step
//   at_max : out is all ones
//   at_min : out is zero
// ---------------------------------------------------------------------------
module my_pc_n
    import my_pc_pkg::*;
#(
    parameter int     WIDTH    = 16,
    parameter longint STEP     = 1,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    // Illegal configurations are rejected at elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("my_pc_n: WIDTH must be in 2..32");
    end
    if (STEP < 1 || STEP > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_bad_step
        $error("my_pc_n: STEP must be in 1..2^WIDTH-1");
    end

    pc_op_e           op;
    logic [WIDTH-1:0] out_d, out_q;
    logic             ovf_d, ovf_q;
    logic [WIDTH-1:0] step_sum;
    logic             step_carry;

    my_step_adder_n #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step_adder (
        .a     (out_q),
        .sub   (op == OP_DEC),
        .sum   (step_sum),
        .carry (step_carry)
    );

    // Next-state: ovf defaults low so it only ever pulses for one cycle.
    // In saturate mode an out-of-range step clamps to the end it ran into.
    always_comb begin
        op    = decode_op(clr, load, inc, dec);
        out_d = out_q;
        ovf_d = 1'b0;
        case (op)
            OP_CLR: begin
                out_d = '0;
            end
            OP_LOAD: begin
                out_d = d;
            end
            OP_INC, OP_DEC: begin
                ovf_d = step_carry;
                if (SATURATE != 0 && step_carry) begin
                    out_d = (op == OP_INC) ? '1 : '0;
                end else begin
                    out_d = step_sum;
                end
            end
            default: begin
                out_d = out_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out    = out_q;
    assign ovf    = ovf_q;
    assign at_max = &out_q;
    assign at_min = ~|out_q;

endmodule

// File: tb/tb_my_pc_n.sv
// ---------------------------------------------------------------------------
// tb_my_pc_n
// Directed bench for my_pc_n with three instances sharing clock and reset:
//   dut_a : WIDTH=16, STEP=1, wrap
//   dut_b : WIDTH=16, STEP=1, saturate
//   dut_c : WIDTH=4,  STEP=3, wrap
// ---------------------------------------------------------------------------
module tb_my_pc_n;

    logic clk;
    logic rst_n;

    logic        clr_a, load_a, inc_a, dec_a;
    logic [15:0] d_a, out_a;
    logic        ovf_a, at_max_a, at_min_a;

    logic        clr_b, load_b, inc_b, dec_b;
    logic [15:0] d_b, out_b;
    logic        ovf_b, at_max_b, at_min_b;

    logic        clr_c, load_c, inc_c, dec_c;
    logic [3:0]  d_c, out_c;
    logic        ovf_c, at_max_c, at_min_c;

    int numCompared;
    int numMismatched;

    my_pc_n #(.WIDTH(16), .STEP(1), .SATURATE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .load(load_a), .d(d_a),
        .inc(inc_a), .dec(dec_a), .out(out_a), .ovf(ovf_a),
        .at_max(at_max_a), .at_min(at_min_a)
    );

    my_pc_n #(.WIDTH(16), .STEP(1), .SATURATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .load(load_b), .d(d_b),
        .inc(inc_b), .dec(dec_b), .out(out_b), .ovf(ovf_b),
        .at_max(at_max_b), .at_min(at_min_b)
    );

    my_pc_n #(.WIDTH(4), .STEP(3), .SATURATE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .load(load_c), .d(d_c),
        .inc(inc_c), .dec(dec_c), .out(out_c), .ovf(ovf_c),
        .at_max(at_max_c), .at_min(at_min_c)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleAll();
        {clr_a, load_a, inc_a, dec_a} = 4'b0000;
        {clr_b, load_b, inc_b, dec_b} = 4'b0000;
        {clr_c, load_c, inc_c, dec_c} = 4'b0000;
        d_a = '0;
        d_b = '0;
        d_c = '0;
    endtask

    // Drive one command on one instance for a single edge; sampling happens
    // 1 ns after that edge, once the registers have settled.
    task automatic applyStimulus(input int which, input logic clr, input logic load,
                                 input logic inc, input logic dec, input logic [15:0] d);
        idleAll();
        case (which)
            0: begin {clr_a, load_a, inc_a, dec_a} = {clr, load, inc, dec}; d_a = d; end
            1: begin {clr_b, load_b, inc_b, dec_b} = {clr, load, inc, dec}; d_b = d; end
            default: begin {clr_c, load_c, inc_c, dec_c} = {clr, load, inc, dec}; d_c = d[3:0]; end
        endcase
        @(posedge clk);
        #1;
        idleAll();
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        idleAll();
        rst_n = 1'b0;

        // Reset state
        #3;
        checkOutput("reset out", 32'(out_a), 32'h0);
        checkOutput("reset ovf", 32'(ovf_a), 32'h0);
        checkOutput("reset at_min", 32'(at_min_a), 32'h1);
        checkOutput("reset at_max", 32'(at_max_a), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Count up 5, then reset between edges
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkOutput("count5 out", 32'(out_a), 32'h5);
        inc_a = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out", 32'(out_a), 32'h0);
        checkOutput("async reset ovf", 32'(ovf_a), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset holds over edge", 32'(out_a), 32'h0);
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkOutput("first inc after reset", 32'(out_a), 32'h1);

        // Wrap in both directions
        applyStimulus(0, 0, 1, 0, 0, 16'hFFFF);
        checkOutput("load max out", 32'(out_a), 32'hFFFF);
        checkOutput("load max at_max", 32'(at_max_a), 32'h1);
        checkOutput("load ovf", 32'(ovf_a), 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkOutput("wrap up out", 32'(out_a), 32'h0);
        checkOutput("wrap up at_min", 32'(at_min_a), 32'h1);
        checkOutput("wrap up ovf", 32'(ovf_a), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        checkOutput("ovf one cycle", 32'(ovf_a), 32'h0);
        checkOutput("hold out", 32'(out_a), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkOutput("wrap down out", 32'(out_a), 32'hFFFF);
        checkOutput("wrap down ovf", 32'(ovf_a), 32'h1);

        // Priority
        applyStimulus(0, 1, 1, 1, 0, 16'h1234);
        checkOutput("clr wins out", 32'(out_a), 32'h0);
        checkOutput("clr clears ovf", 32'(ovf_a), 32'h0);
        applyStimulus(0, 0, 1, 1, 0, 16'h1234);
        checkOutput("load beats inc", 32'(out_a), 32'h1234);
        applyStimulus(0, 0, 1, 0, 0, 16'hFFFF);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkOutput("pre-hold ovf", 32'(ovf_a), 32'h1);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkOutput("inc+dec hold out", 32'(out_a), 32'h0);
        checkOutput("inc+dec hold ovf", 32'(ovf_a), 32'h0);
        applyStimulus(0, 0, 1, 0, 0, 16'h1234);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkOutput("plain dec", 32'(out_a), 32'h1233);

        // Saturation
        applyStimulus(1, 0, 1, 0, 0, 16'hFFFE);
        checkOutput("sat load", 32'(out_b), 32'hFFFE);
        applyStimulus(1, 0, 0, 1, 0, 16'h0);
        checkOutput("sat inc1 out", 32'(out_b), 32'hFFFF);
        checkOutput("sat inc1 ovf", 32'(ovf_b), 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 16'h0);
        checkOutput("sat inc2 out", 32'(out_b), 32'hFFFF);
        checkOutput("sat inc2 ovf", 32'(ovf_b), 32'h1);
        applyStimulus(1, 0, 0, 1, 0, 16'h0);
        checkOutput("sat inc3 out", 32'(out_b), 32'hFFFF);
        checkOutput("sat inc3 ovf", 32'(ovf_b), 32'h1);
        checkOutput("sat at_max", 32'(at_max_b), 32'h1);
        applyStimulus(1, 0, 1, 0, 0, 16'h0001);
        applyStimulus(1, 0, 0, 0, 1, 16'h0);
        checkOutput("sat dec to zero", 32'(out_b), 32'h0);
        checkOutput("sat dec to zero ovf", 32'(ovf_b), 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 16'h0);
        checkOutput("sat dec clamp out", 32'(out_b), 32'h0);
        checkOutput("sat dec clamp ovf", 32'(ovf_b), 32'h1);
        checkOutput("sat at_min", 32'(at_min_b), 32'h1);

        // Non-unit step, narrow width
        applyStimulus(2, 0, 1, 0, 0, 16'd14);
        checkOutput("step3 load", 32'(out_c), 32'd14);
        applyStimulus(2, 0, 0, 1, 0, 16'h0);
        checkOutput("step3 inc out", 32'(out_c), 32'd1);
        checkOutput("step3 inc ovf", 32'(ovf_c), 32'h1);
        applyStimulus(2, 0, 0, 0, 1, 16'h0);
        checkOutput("step3 dec out", 32'(out_c), 32'd14);
        checkOutput("step3 dec ovf", 32'(ovf_c), 32'h1);
        applyStimulus(2, 0, 0, 0, 1, 16'h0);
        checkOutput("step3 dec2 out", 32'(out_c), 32'd11);
        checkOutput("step3 dec2 ovf", 32'(ovf_c), 32'h0);
        applyStimulus(2, 0, 1, 0, 0, 16'd15);
        checkOutput("step3 at_max", 32'(at_max_c), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
